// File: rtl/gpio_irq_detect_if.sv
// gpio_irq_detect_if: GPIO interrupt configuration, input and status bundle
interface gpio_irq_detect_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] aux_i;
  logic [WIDTH-1:0] irq_en;
  logic [WIDTH-1:0] irq_type;
  logic [WIDTH-1:0] irq_pol;
  logic [WIDTH-1:0] irq_both;
  logic [WIDTH-1:0] irq_clr;
  logic [WIDTH-1:0] irq_status;
  logic [WIDTH-1:0] irq_ovf;
  logic             irq;
  modport master (output aux_i, irq_en, irq_type, irq_pol, irq_both, irq_clr, input irq_status, irq_ovf, irq);
  modport slave  (input aux_i, irq_en, irq_type, irq_pol, irq_both, irq_clr, output irq_status, irq_ovf, irq);
endinterface

// File: rtl/gpio_irq_detect.sv
// gpio_irq_detect: per-bit edge/level GPIO interrupt detection with sticky status and overflow
module gpio_irq_detect #(parameter int WIDTH = 32) (
  input logic         sys_clk,
  input logic         sys_rst,
  gpio_irq_detect_if.slave bus
);
  logic [WIDTH-1:0] prev_q, status_q, ovf_q, edge_ev, level_ev, event_w;
  logic             valid_q;
  always_comb begin
    edge_ev  = bus.irq_both & (bus.aux_i ^ prev_q)
             | ~bus.irq_both & (bus.irq_pol & bus.aux_i & ~prev_q | ~bus.irq_pol & ~bus.aux_i & prev_q);
    level_ev = ~(bus.aux_i ^ bus.irq_pol);
    event_w  = bus.irq_en & (bus.irq_type & edge_ev & {WIDTH{valid_q}} | ~bus.irq_type & level_ev);
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      prev_q   <= '0;
      valid_q  <= 1'b0;
      status_q <= '0;
      ovf_q    <= '0;
    end else begin
      prev_q   <= bus.aux_i;
      valid_q  <= 1'b1;
      status_q <= event_w | (status_q & ~bus.irq_clr);
      // overflow is an edge-mode notion: a held level re-sets status every cycle
      ovf_q    <= (event_w & bus.irq_type & status_q & ~bus.irq_clr) | (ovf_q & ~bus.irq_clr);
    end
  end
  assign bus.irq_status = status_q;
  assign bus.irq_ovf    = ovf_q;
  assign bus.irq        = |status_q;
endmodule

// File: tb/tb_gpio_irq_detect.sv
// tb_gpio_irq_detect: directed self-checking bench for gpio_irq_detect
module tb_gpio_irq_detect;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int total = 0;
  int bad = 0;
  gpio_irq_detect_if #(.WIDTH(32)) bus ();
  gpio_irq_detect #(.WIDTH(32)) dut (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus));
  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic cfg(input logic [31:0] en, input logic [31:0] typ, input logic [31:0] pol, input logic [31:0] both);
    bus.irq_en = en;
    bus.irq_type = typ;
    bus.irq_pol = pol;
    bus.irq_both = both;
    bus.irq_clr = '0;
  endtask

  task automatic do_reset(input logic [31:0] aux);
    bus.aux_i = aux;
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    cfg('0, '0, '0, '0);
    do_reset('0);
    sys_rst = 1'b1;
    step();
    total++; if (bus.irq_status !== 32'h0) begin bad++; $display("FAIL reset_status got=%h exp=%h", bus.irq_status, 32'h0); end
    total++; if (bus.irq_ovf !== 32'h0) begin bad++; $display("FAIL reset_ovf got=%h exp=%h", bus.irq_ovf, 32'h0); end
    total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", bus.irq); end
  endtask

  task automatic test_edge_rise();
    cfg(32'h1, 32'h1, 32'h1, 32'h0);
    do_reset('0);
    step();
    bus.aux_i = 32'h1;
    step();
    total++; if (bus.irq_status !== 32'h1) begin bad++; $display("FAIL rise_status got=%h exp=%h", bus.irq_status, 32'h1); end
    total++; if (bus.irq !== 1'b1) begin bad++; $display("FAIL rise_irq got=%b exp=1", bus.irq); end
    bus.irq_clr = 32'h1;
    step();
    bus.irq_clr = '0;
    total++; if (bus.irq_status !== 32'h0) begin bad++; $display("FAIL rise_clr got=%h exp=%h", bus.irq_status, 32'h0); end
    step();
    total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL rise_hold_irq got=%b exp=0", bus.irq); end
  endtask

  task automatic test_both_edges();
    cfg(32'h8, 32'h8, 32'h0, 32'h8);
    do_reset('0);
    step();
    bus.aux_i = 32'h8;
    step();
    total++; if (bus.irq_status !== 32'h8) begin bad++; $display("FAIL both_rise got=%h exp=%h", bus.irq_status, 32'h8); end
    bus.irq_clr = 32'h8;
    step();
    bus.irq_clr = '0;
    total++; if (bus.irq_status !== 32'h0) begin bad++; $display("FAIL both_clr1 got=%h exp=%h", bus.irq_status, 32'h0); end
    bus.aux_i = 32'h0;
    step();
    total++; if (bus.irq_status !== 32'h8) begin bad++; $display("FAIL both_fall got=%h exp=%h", bus.irq_status, 32'h8); end
    total++; if (bus.irq_ovf !== 32'h0) begin bad++; $display("FAIL both_no_ovf got=%h exp=%h", bus.irq_ovf, 32'h0); end
    bus.irq_clr = 32'h8;
    step();
    bus.irq_clr = '0;
    bus.aux_i = 32'h8;
    step();
    bus.aux_i = 32'h0;
    step();
    total++; if (bus.irq_ovf !== 32'h8) begin bad++; $display("FAIL both_ovf got=%h exp=%h", bus.irq_ovf, 32'h8); end
    bus.irq_clr = 32'h8;
    step();
    bus.irq_clr = '0;
    total++; if (bus.irq_ovf !== 32'h0) begin bad++; $display("FAIL both_ovf_clr got=%h exp=%h", bus.irq_ovf, 32'h0); end
  endtask

  task automatic test_level();
    cfg(32'h20, 32'h0, 32'h0, 32'h0);
    do_reset('0);
    step();
    total++; if (bus.irq_status !== 32'h20) begin bad++; $display("FAIL level_first got=%h exp=%h", bus.irq_status, 32'h20); end
    bus.irq_clr = 32'h20;
    step();
    bus.irq_clr = '0;
    total++; if (bus.irq_status !== 32'h20) begin bad++; $display("FAIL level_hold got=%h exp=%h", bus.irq_status, 32'h20); end
    step();
    total++; if (bus.irq_ovf !== 32'h0) begin bad++; $display("FAIL level_ovf got=%h exp=%h", bus.irq_ovf, 32'h0); end
    bus.aux_i = 32'h20;
    bus.irq_clr = 32'h20;
    step();
    bus.irq_clr = '0;
    total++; if (bus.irq_status !== 32'h0) begin bad++; $display("FAIL level_clr got=%h exp=%h", bus.irq_status, 32'h0); end
  endtask

  task automatic test_set_clr();
    cfg(32'h2, 32'h2, 32'h2, 32'h0);
    do_reset('0);
    step();
    bus.aux_i = 32'h2;
    bus.irq_clr = 32'h2;
    step();
    bus.irq_clr = '0;
    total++; if (bus.irq_status !== 32'h2) begin bad++; $display("FAIL setclr_status got=%h exp=%h", bus.irq_status, 32'h2); end
    total++; if (bus.irq_ovf !== 32'h0) begin bad++; $display("FAIL setclr_ovf got=%h exp=%h", bus.irq_ovf, 32'h0); end
  endtask

  task automatic test_reset_suppress();
    cfg('1, '1, '1, '0);
    do_reset('1);
    step();
    total++; if (bus.irq_status !== 32'h0) begin bad++; $display("FAIL sup_first got=%h exp=%h", bus.irq_status, 32'h0); end
    step();
    total++; if (bus.irq_status !== 32'h0) begin bad++; $display("FAIL sup_second got=%h exp=%h", bus.irq_status, 32'h0); end
    bus.aux_i = 32'h0;
    step();
    bus.aux_i = 32'h1;
    step();
    bus.aux_i = 32'h0;
    step();
    bus.aux_i = 32'h1;
    step();
    total++; if (bus.irq_ovf !== 32'h1) begin bad++; $display("FAIL mid_ovf got=%h exp=%h", bus.irq_ovf, 32'h1); end
    bus.aux_i = 32'h3;
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    total++; if (bus.irq_status !== 32'h0) begin bad++; $display("FAIL mid_rst_status got=%h exp=%h", bus.irq_status, 32'h0); end
    total++; if (bus.irq_ovf !== 32'h0) begin bad++; $display("FAIL mid_rst_ovf got=%h exp=%h", bus.irq_ovf, 32'h0); end
  endtask

  task automatic test_enable();
    cfg(32'h0, 32'h80, 32'h80, 32'h0);
    do_reset('0);
    step();
    bus.aux_i = 32'h80;
    step();
    total++; if (bus.irq_status !== 32'h0) begin bad++; $display("FAIL en_off got=%h exp=%h", bus.irq_status, 32'h0); end
    bus.aux_i = 32'h0;
    bus.irq_en = 32'h80;
    step();
    bus.aux_i = 32'h80;
    step();
    total++; if (bus.irq_status !== 32'h80) begin bad++; $display("FAIL en_on got=%h exp=%h", bus.irq_status, 32'h80); end
    bus.irq_en = 32'h0;
    bus.aux_i = 32'h0;
    step();
    bus.aux_i = 32'h80;
    step();
    total++; if (bus.irq_status !== 32'h80) begin bad++; $display("FAIL en_persist got=%h exp=%h", bus.irq_status, 32'h80); end
    total++; if (bus.irq_ovf !== 32'h0) begin bad++; $display("FAIL en_no_ovf got=%h exp=%h", bus.irq_ovf, 32'h0); end
  endtask

  task automatic test_independent();
    cfg(32'h5, 32'h1, 32'h5, 32'h0);
    do_reset('0);
    step();
    total++; if (bus.irq_status !== 32'h0) begin bad++; $display("FAIL ind_idle got=%h exp=%h", bus.irq_status, 32'h0); end
    bus.aux_i = 32'h5;
    step();
    total++; if (bus.irq_status !== 32'h5) begin bad++; $display("FAIL ind_both got=%h exp=%h", bus.irq_status, 32'h5); end
    bus.aux_i = 32'h1;
    bus.irq_clr = 32'h5;
    step();
    bus.irq_clr = '0;
    total++; if (bus.irq_status !== 32'h0) begin bad++; $display("FAIL ind_clr got=%h exp=%h", bus.irq_status, 32'h0); end
  endtask

  initial begin
    cfg('0, '0, '0, '0);
    bus.aux_i = '0;
    test_reset();
    test_edge_rise();
    test_both_edges();
    test_level();
    test_set_clr();
    test_reset_suppress();
    test_enable();
    test_independent();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
